// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared Wishbone definitions for the register slave and its helpers.
//   ADDR_WIDTH / DATA_WIDTH : mirror the shared `ADDR_WIDTH / `DATA_WIDTH defines
//                             (default 8 / 32 when no build-wide define exists)
//   wb_addr_t / wb_data_t   : address and data word types
//   ID_VALUE_DEF            : default constant of the optional ID register
//   addr_in_range()         : true when a word address selects an existing register
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package wb_pkg;

   localparam int ADDR_WIDTH = `ADDR_WIDTH;
   localparam int DATA_WIDTH = `DATA_WIDTH;

   typedef logic [ADDR_WIDTH-1:0] wb_addr_t;
   typedef logic [DATA_WIDTH-1:0] wb_data_t;

   localparam wb_data_t ID_VALUE_DEF = wb_data_t'(32'hC0DE_0001);

   // Address is unsigned; the size cast zero-extends before the compare.
   function automatic logic addr_in_range(input wb_addr_t adr, input int unsigned num_regs);
      return (32'(adr) < num_regs);
   endfunction

endpackage

// File: rtl/wb_slave_register_if.sv
// -----------------------------------------------------------------------------
// wb_slave_register_if
// Wishbone classic (B3) bus bundle between one master and the register slave.
//   adr_i  : word address            (master -> slave)
//   dat_i  : write data              (master -> slave)
//   we_i   : 1 = write, 0 = read     (master -> slave)
//   cyc_i  : bus cycle in progress   (master -> slave)
//   stb_i  : strobe / slave select   (master -> slave)
//   dat_o  : read data               (slave -> master)
//   ack_o  : transfer acknowledge    (slave -> master)
// Handshake: a request is cyc_i & stb_i & ~ack_o sampled at a rising clock
// edge; the slave answers with ack_o high for exactly one cycle on the next
// cycle, with read data valid on dat_o in that same cycle. The master holds
// adr_i/dat_i/we_i stable while cyc_i & stb_i are high and no ack has come.
// -----------------------------------------------------------------------------
interface wb_slave_register_if;
   import wb_pkg::*;

   wb_addr_t adr_i;
   wb_data_t dat_i;
   logic     we_i;
   logic     cyc_i;
   logic     stb_i;
   wb_data_t dat_o;
   logic     ack_o;

   modport master (
      output adr_i, dat_i, we_i, cyc_i, stb_i,
      input  dat_o, ack_o
   );

   modport slave (
      input  adr_i, dat_i, we_i, cyc_i, stb_i,
      output dat_o, ack_o
   );

endinterface

// File: rtl/wb_slave_ack_gen.sv
// -----------------------------------------------------------------------------
// wb_slave_ack_gen
// One-cycle acknowledge generator: turns a sampled request into a single-cycle
// ack pulse on the following cycle.
//   clk_i  : bus clock, rising edge
//   rst_i  : asynchronous active-low reset
//   i_cyc  : bus cycle in progress
//   i_stb  : slave strobe
//   o_req  : request accepted at the coming edge (cyc & stb & ~ack)
//   o_ack  : registered acknowledge
// -----------------------------------------------------------------------------
module wb_slave_ack_gen (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_cyc,
   input  logic i_stb,
   output logic o_req,
   output logic o_ack
);

   logic r_ack;

   // Masking with the current ack forces a gap cycle, so a master holding
   // stb high sees one ack per access instead of a continuous ack.
   assign o_req = i_cyc & i_stb & ~r_ack;
   assign o_ack = r_ack;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ack <= 1'b0;
      end else begin
         r_ack <= o_req;
      end
   end

endmodule

// File: rtl/wb_slave_register.sv
// -----------------------------------------------------------------------------
// wb_slave_register
// Wishbone classic (B3) slave with a bank of NUM_REGS word-wide read/write
// registers. Every single read/write cycle is acknowledged one cycle after the
// request; reads return registered data alongside ack, out-of-range reads
// return 0 and out-of-range writes are acknowledged but dropped.
//   clk_i : bus clock, rising edge
//   rst_i : asynchronous active-low reset (clears ack, dat_o and registers)
//   bus   : wb_slave_register_if.slave (adr_i, dat_i, we_i, cyc_i, stb_i,
//           dat_o, ack_o)
// Parameters:
//   NUM_REGS : number of registers, 2 .. 2**ADDR_WIDTH
//   ID_VALUE : constant of the ID register (only with WB_SLAVE_REGISTER_ID_EN)
// Build option:
//   WB_SLAVE_REGISTER_ID_EN : when defined, register NUM_REGS-1 is a read-only
//   ID register returning ID_VALUE; writes to it are acknowledged and ignored.
//   When undefined it is an ordinary read/write register.
// -----------------------------------------------------------------------------
module wb_slave_register
   import wb_pkg::*;
#(
   parameter int NUM_REGS = 16
`ifdef WB_SLAVE_REGISTER_ID_EN
   ,
   parameter wb_data_t ID_VALUE = ID_VALUE_DEF
`endif
) (
   input logic                clk_i,
   input logic                rst_i,
   wb_slave_register_if.slave bus
);

`ifdef WB_SLAVE_REGISTER_ID_EN
   localparam int NUM_RW = NUM_REGS - 1;
`else
   localparam int NUM_RW = NUM_REGS;
`endif

   logic     w_req;
   logic     w_ack;
   logic     w_in_range;
   wb_data_t w_rd_data;
   wb_data_t w_reg_q [NUM_REGS];
   wb_data_t r_dat_o;

   wb_slave_ack_gen u_ack_gen (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .i_cyc (bus.cyc_i),
      .i_stb (bus.stb_i),
      .o_req (w_req),
      .o_ack (w_ack)
   );

   assign bus.ack_o = w_ack;
   assign bus.dat_o = r_dat_o;

   // Writable registers; each one loads on the edge that raises ack.
   for (genvar g = 0; g < NUM_RW; g++) begin : g_reg
      logic     w_wr_en;
      wb_data_t r_q;

      assign w_wr_en    = w_req & bus.we_i & (bus.adr_i == ADDR_WIDTH'(g));
      assign w_reg_q[g] = r_q;

      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i) begin
            r_q <= '0;
         end else if (w_wr_en) begin
            r_q <= bus.dat_i;
         end
      end
   end

`ifdef WB_SLAVE_REGISTER_ID_EN
   // Hard-wired, so reset and writes can never disturb it.
   assign w_reg_q[NUM_REGS-1] = ID_VALUE;
`endif

   assign w_in_range = addr_in_range(bus.adr_i, NUM_REGS);

   // Compare-based mux keeps the index width independent of NUM_REGS.
   always_comb begin
      w_rd_data = '0;
      if (w_in_range) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.adr_i == ADDR_WIDTH'(i)) begin
               w_rd_data = w_reg_q[i];
            end
         end
      end
   end

   // Read data exists only in the ack cycle of a read; zero otherwise,
   // including write acks.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_dat_o <= '0;
      end else if (w_req && !bus.we_i) begin
         r_dat_o <= w_rd_data;
      end else begin
         r_dat_o <= '0;
      end
   end

endmodule

// File: tb/tb_wb_slave_register.sv
module tb_wb_slave_register;
  import wb_pkg::*;

  localparam int NUM_REGS = 16;

  logic clk;
  logic rst_n;

  wb_slave_register_if bus ();

  wb_slave_register #(.NUM_REGS(NUM_REGS)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [DATA_WIDTH-1:0] model [NUM_REGS];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DATA_WIDTH-1:0] got,
                       input logic [DATA_WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] model_read(input logic [ADDR_WIDTH-1:0] adr);
    if (int'(adr) >= NUM_REGS) return '0;
`ifdef WB_SLAVE_REGISTER_ID_EN
    if (int'(adr) == NUM_REGS-1) return 32'hC0DE_0001;
`endif
    return model[int'(adr)];
  endfunction

  task automatic model_write(input logic [ADDR_WIDTH-1:0] adr, input logic [DATA_WIDTH-1:0] data);
    if (int'(adr) < NUM_REGS) model[int'(adr)] = data;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask

  // ---------------- monitor: pop expected data on every ack ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ack_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_ack", 32'd1, 32'd0);
        end else begin
          check("ack_data", bus.dat_o, exp_q.pop_front());
        end
      end else begin
        check("dat_idle", bus.dat_o, '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = '0;
    bus.dat_i = '0;
  endtask

  // One single-access cycle; ack must appear exactly one cycle after request.
  task automatic do_access(input logic we, input logic [ADDR_WIDTH-1:0] adr,
                           input logic [DATA_WIDTH-1:0] data);
    @(posedge clk); #1;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = we;
    bus.adr_i = adr;
    bus.dat_i = data;
    if (we) begin
      exp_q.push_back('0);
      model_write(adr, data);
    end else begin
      exp_q.push_back(model_read(adr));
    end
    @(negedge clk);
    check("ack_early", {31'b0, bus.ack_o}, 32'd0);
    @(negedge clk);
    check("ack_rsp", {31'b0, bus.ack_o}, 32'd1);
    @(posedge clk); #1;
    bus_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_we;
    logic [3:0]            ack_pat;

    bus_idle();
    model_clear();
    rst_n = 1'b0;
    #12;
    check("rst_ack", {31'b0, bus.ack_o}, 32'd0);
    check("rst_dat", bus.dat_o, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic read of a cleared register
    do_access(1'b0, 8'h00, '0);

    // write then read back; neighbour untouched
    do_access(1'b1, 8'h03, 32'hDEAD_BEEF);
    do_access(1'b0, 8'h03, '0);
    do_access(1'b0, 8'h02, '0);

    // out of range read and write
    do_access(1'b0, 8'h40, '0);
    do_access(1'b1, 8'h40, 32'h0000_1234);
    for (int i = 0; i < NUM_REGS; i++) do_access(1'b0, ADDR_WIDTH'(i), '0);

    // master holds stb high for four cycles: ack pattern 0,1,0,1
    @(posedge clk); #1;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b0;
    bus.adr_i = 8'h03;
    exp_q.push_back(model_read(8'h03));
    exp_q.push_back(model_read(8'h03));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ack_pat[3-i] = bus.ack_o;
    end
    check("hold_ack_pattern", {28'b0, ack_pat}, 32'h5);
    @(posedge clk); #1;
    bus_idle();

    // random traffic, including out-of-range addresses
    for (int i = 0; i < 40; i++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_adr = ADDR_WIDTH'($urandom_range(0, 31));
      r_dat = $urandom;
      do_access(r_we, r_adr, r_dat);
    end

    // top register: ID (read-only) or ordinary depending on the build
    do_access(1'b1, 8'h0F, 32'hFFFF_FFFF);
    do_access(1'b0, 8'h0F, '0);
`ifdef WB_SLAVE_REGISTER_ID_EN
    check("id_model", model_read(8'h0F), 32'hC0DE_0001);
`endif

    // reset in the middle of a write ack
    do_access(1'b1, 8'h01, 32'h1111_2222);
    @(posedge clk); #1;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b1;
    bus.adr_i = 8'h01;
    bus.dat_i = 32'hA5A5_A5A5;
    @(posedge clk); #2;
    check("pre_rst_ack", {31'b0, bus.ack_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ack", {31'b0, bus.ack_o}, 32'd0);
    check("async_rst_dat", bus.dat_o, '0);
    bus_idle();
    exp_q.delete();
    model_clear();
    #1;
    rst_n = 1'b1;

    do_access(1'b0, 8'h01, '0);
    do_access(1'b0, 8'h03, '0);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
